// File: rtl/opfetch_pkg.sv
// opfetch_pkg: state, mux and mode codes shared by the operand fetch sequencer.
// Also holds the constant-generator lookup used when OPFETCH_CONST_GEN_EN is defined.
package opfetch_pkg;

  typedef logic [3:0] stateT;

  localparam stateT IDLE   = 4'd0;
  localparam stateT S_EXT  = 4'd1;
  localparam stateT S_ADDR = 4'd2;
  localparam stateT S_RD   = 4'd3;
  localparam stateT S_LAT  = 4'd4;
  localparam stateT D_EXT  = 4'd5;
  localparam stateT D_ADDR = 4'd6;
  localparam stateT D_RD   = 4'd7;
  localparam stateT D_LAT  = 4'd8;
  localparam stateT VALID  = 4'd9;

  localparam logic [1:0] ADDR_LATCH   = 2'd0;
  localparam logic [1:0] ADDR_RSRC_M2 = 2'd1;
  localparam logic [1:0] ADDR_RSRC    = 2'd2;
  localparam logic [1:0] ADDR_RDST    = 2'd3;

  localparam logic [1:0] FMT_DOUBLE = 2'd0;
  localparam logic [1:0] FMT_SINGLE = 2'd1;
  localparam logic [1:0] FMT_JUMP   = 2'd2;
  localparam logic [1:0] FMT_RSVD   = 2'd3;

  localparam logic [1:0] MODE_REG      = 2'd0;
  localparam logic [1:0] MODE_INDEX    = 2'd1;
  localparam logic [1:0] MODE_INDIRECT = 2'd2;
  localparam logic [1:0] MODE_AUTOINC  = 2'd3;

  localparam logic [3:0] CG_R2 = 4'd2;
  localparam logic [3:0] CG_R3 = 4'd3;

  typedef struct packed {
    logic [1:0] fmt;
    logic [1:0] as;
    logic       ad;
    logic       bw;
    logic       noDstRd;
    logic [3:0] rsNum;
    logic [3:0] rdNum;
  } instrT;

  // R2 indexed stays absolute addressing, so only its indirect modes generate constants.
  function automatic logic isConstGen(input logic [3:0] rsNum, input logic [1:0] as);
    return (rsNum == CG_R3) || ((rsNum == CG_R2) && as[1]);
  endfunction

  function automatic logic [15:0] constGenValue(input logic [3:0] rsNum, input logic [1:0] as);
    logic [15:0] val;
    if (rsNum == CG_R2) begin
      val = as[0] ? 16'h0008 : 16'h0004;
    end else begin
      case (as)
        2'd0:    val = 16'h0000;
        2'd1:    val = 16'h0001;
        2'd2:    val = 16'h0002;
        default: val = 16'hFFFF;
      endcase
    end
    return val;
  endfunction

endpackage

// File: rtl/opfetch_incr.sv
// opfetch_incr: auto-increment step; word-sized for word ops and always for PC/SP.
module opfetch_incr #(
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] SP_REG = 4'd1
) (
  input  logic [3:0] regNum,
  input  logic       bw,
  output logic [1:0] amt
);

  assign amt = (!bw || (regNum == PC_REG) || (regNum == SP_REG)) ? 2'd2 : 2'd1;

endmodule

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: steps the operand fetch datapath through one instruction's addressing modes.
// Optional constant generator for R2/R3 source encodings under `OPFETCH_CONST_GEN_EN.
//
// state  | meaning
// IDLE   | waiting for start from decode
// S_EXT  | fetch source index extension word
// S_ADDR | form source address in address latch
// S_RD   | source memory read (optional auto-increment)
// S_LAT  | latch source operand from MDB
// D_EXT  | fetch destination index extension word
// D_ADDR | form destination address in address latch
// D_RD   | destination memory read
// D_LAT  | latch destination operand from MDB
// VALID  | operands presented to execute until op_ack
module operand_fetch_seq
  import opfetch_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] SP_REG = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  fmt,
  input  logic [1:0]  As,
  input  logic        Ad,
  input  logic        bw,
  input  logic        no_dst_rd,
  input  logic [3:0]  rs_num,
  input  logic [3:0]  rd_num,
  input  logic        op_ack,
  output logic        busy,
  output logic        op_valid,
  output logic        ifetch_req,
  output logic        mem_rd,
  output logic        reg_inc,
  output logic [3:0]  reg_inc_sel,
  output logic [1:0]  reg_inc_amt,
  output logic        srcM,
  output logic        srcL,
  output logic        dstM,
  output logic        dstL,
  output logic        AddrL,
  output logic        IdxM,
  output logic [1:0]  AddrM
`ifdef OPFETCH_CONST_GEN_EN
  ,
  output logic        cg_valid,
  output logic [15:0] cg_val
`endif
);

  stateT      state, stateNext;
  instrT      instr, instrIn;
  logic       srcHeld, dstHeld;
  logic       cgHit, singleOp, incSrc, incDst, leaveValid;
  logic [3:0] incReg;
  logic [1:0] incAmt;

  function automatic stateT dstEntry(input logic ad);
    return ad ? D_EXT : VALID;
  endfunction

  assign instrIn    = {fmt, As, Ad, bw, no_dst_rd, rs_num, rd_num};
  assign singleOp   = (instr.fmt == FMT_SINGLE);
  assign leaveValid = (state == VALID) && op_ack;

`ifdef OPFETCH_CONST_GEN_EN
  assign cgHit = (fmt == FMT_DOUBLE) && isConstGen(rs_num, As);
`else
  assign cgHit = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (fmt[1]) begin
            stateNext = VALID;
          end else if (fmt == FMT_SINGLE) begin
            case (As)
              MODE_REG:   stateNext = VALID;
              MODE_INDEX: stateNext = D_EXT;
              default:    stateNext = D_RD;
            endcase
          end else if (cgHit || (As == MODE_REG)) begin
            stateNext = dstEntry(Ad);
          end else if (As == MODE_INDEX) begin
            stateNext = S_EXT;
          end else begin
            stateNext = S_RD;
          end
        end
      end
      S_EXT:  stateNext = S_ADDR;
      S_ADDR: stateNext = S_RD;
      S_RD:   stateNext = S_LAT;
      S_LAT:  stateNext = dstEntry(instr.ad);
      D_EXT:  stateNext = D_ADDR;
      // write-only destinations only need the address, not the old contents
      D_ADDR: stateNext = (!singleOp && instr.noDstRd) ? VALID : D_RD;
      D_RD:   stateNext = D_LAT;
      D_LAT:  stateNext = VALID;
      VALID:  if (op_ack) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      instr   <= '0;
      srcHeld <= 1'b0;
      dstHeld <= 1'b0;
    end else begin
      state <= stateNext;
      if ((state == IDLE) && start) instr <= instrIn;
      if (leaveValid) begin
        srcHeld <= 1'b0;
        dstHeld <= 1'b0;
      end else begin
        if (state == S_LAT) srcHeld <= 1'b1;
        if (state == D_LAT) dstHeld <= 1'b1;
      end
    end
  end

`ifdef OPFETCH_CONST_GEN_EN
  logic        cgHeld;
  logic [15:0] cgReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cgHeld <= 1'b0;
      cgReg  <= '0;
    end else if ((state == IDLE) && start && cgHit) begin
      cgHeld <= 1'b1;
      cgReg  <= constGenValue(rs_num, As);
    end else if (leaveValid) begin
      cgHeld <= 1'b0;
      cgReg  <= '0;
    end
  end

  assign cg_valid = cgHeld;
  assign cg_val   = cgReg;
`endif

  assign incSrc = (state == S_RD) && (instr.as == MODE_AUTOINC);
  assign incDst = (state == D_RD) && singleOp && (instr.as == MODE_AUTOINC);
  assign incReg = incSrc ? instr.rsNum : instr.rdNum;

  opfetch_incr #(
    .PC_REG(PC_REG),
    .SP_REG(SP_REG)
  ) uIncr (
    .regNum(incReg),
    .bw    (instr.bw),
    .amt   (incAmt)
  );

  assign busy        = (state != IDLE);
  assign op_valid    = (state == VALID);
  assign ifetch_req  = (state == S_EXT) || (state == D_EXT);
  assign mem_rd      = (state == S_RD) || (state == D_RD);
  assign reg_inc     = incSrc || incDst;
  assign reg_inc_sel = reg_inc ? incReg : 4'd0;
  assign reg_inc_amt = reg_inc ? incAmt : 2'd0;
  assign srcL        = (state == S_LAT);
  assign dstL        = (state == D_LAT);
  assign AddrL       = (state == S_ADDR) || (state == D_ADDR);
  assign IdxM        = (state == D_ADDR);
  assign srcM        = srcHeld;
  assign dstM        = dstHeld || (state == D_LAT);

  // indexed reads go through the address latch; indirect reads use the register directly
  always_comb begin
    AddrM = ADDR_LATCH;
    if ((state == S_RD) && (instr.as != MODE_INDEX)) begin
      AddrM = ADDR_RSRC;
    end else if ((state == D_RD) && singleOp && (instr.as != MODE_INDEX)) begin
      AddrM = ADDR_RDST;
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: scoreboard bench; expected per-cycle control traces come from an
// addressing-mode model, and a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_operand_fetch_seq;

  typedef struct packed {
    logic       busy;
    logic       opValid;
    logic       ifetch;
    logic       memRd;
    logic       regInc;
    logic [3:0] incSel;
    logic [1:0] incAmt;
    logic       srcM;
    logic       srcL;
    logic       dstM;
    logic       dstL;
    logic       addrL;
    logic       idxM;
    logic [1:0] addrM;
  } outT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] fmt = 2'd0;
  logic [1:0] As = 2'd0;
  logic       Ad = 1'b0;
  logic       bw = 1'b0;
  logic       no_dst_rd = 1'b0;
  logic [3:0] rs_num = 4'd0;
  logic [3:0] rd_num = 4'd0;
  logic       op_ack = 1'b0;

  logic       busy, op_valid, ifetch_req, mem_rd, reg_inc;
  logic [3:0] reg_inc_sel;
  logic [1:0] reg_inc_amt;
  logic       srcM, srcL, dstM, dstL, AddrL, IdxM;
  logic [1:0] AddrM;
`ifdef OPFETCH_CONST_GEN_EN
  logic        cg_valid;
  logic [15:0] cg_val;
  logic        expCg = 1'b0;
  logic [15:0] expCgVal = 16'd0;
`endif

  int   total = 0;
  int   bad = 0;
  outT  expQ[$];
  outT  heldExp = '0;
  logic prevValid = 1'b0;

  always #5 clk = ~clk;

  operand_fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fmt        (fmt),
    .As         (As),
    .Ad         (Ad),
    .bw         (bw),
    .no_dst_rd  (no_dst_rd),
    .rs_num     (rs_num),
    .rd_num     (rd_num),
    .op_ack     (op_ack),
    .busy       (busy),
    .op_valid   (op_valid),
    .ifetch_req (ifetch_req),
    .mem_rd     (mem_rd),
    .reg_inc    (reg_inc),
    .reg_inc_sel(reg_inc_sel),
    .reg_inc_amt(reg_inc_amt),
    .srcM       (srcM),
    .srcL       (srcL),
    .dstM       (dstM),
    .dstL       (dstL),
    .AddrL      (AddrL),
    .IdxM       (IdxM),
    .AddrM      (AddrM)
`ifdef OPFETCH_CONST_GEN_EN
    ,
    .cg_valid   (cg_valid),
    .cg_val     (cg_val)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic outT outVec();
    return {busy, op_valid, ifetch_req, mem_rd, reg_inc, reg_inc_sel, reg_inc_amt,
            srcM, srcL, dstM, dstL, AddrL, IdxM, AddrM};
  endfunction

  function automatic outT stepBase(input logic sM, input logic dM);
    outT s;
    s = '0;
    s.busy = 1'b1;
    s.srcM = sM;
    s.dstM = dM;
    return s;
  endfunction

  function automatic logic [1:0] incAmount(input logic [3:0] r, input logic b);
    return (!b || r == 4'd0 || r == 4'd1) ? 2'd2 : 2'd1;
  endfunction

`ifdef OPFETCH_CONST_GEN_EN
  function automatic logic [15:0] cgTable(input logic [3:0] r, input logic [1:0] a);
    logic [15:0] r3 [4];
    r3[0] = 16'h0000; r3[1] = 16'h0001; r3[2] = 16'h0002; r3[3] = 16'hFFFF;
    if (r == 4'd2) return (a == 2'd3) ? 16'h0008 : 16'h0004;
    return r3[a];
  endfunction
`endif

  // Model: list the control pulses an operand needs for its addressing mode, one per cycle.
  task automatic fetchOperand(input logic [1:0] a, input logic [3:0] r, input logic b,
                              input logic [1:0] indMux, input logic sM, input logic dM);
    outT s;
    if (a == 2'd1) begin
      s = stepBase(sM, dM); s.ifetch = 1'b1; expQ.push_back(s);
      s = stepBase(sM, dM); s.addrL = 1'b1; s.idxM = (indMux != 2'd2); expQ.push_back(s);
      s = stepBase(sM, dM); s.memRd = 1'b1; expQ.push_back(s);
    end else begin
      s = stepBase(sM, dM); s.memRd = 1'b1; s.addrM = indMux;
      if (a == 2'd3) begin
        s.regInc = 1'b1; s.incSel = r; s.incAmt = incAmount(r, b);
      end
      expQ.push_back(s);
    end
  endtask

  task automatic buildExpected(input logic [1:0] f, input logic [1:0] a, input logic d,
                               input logic b, input logic nd, input logic [3:0] rs,
                               input logic [3:0] rd, output int n);
    outT  s;
    logic sM, dM, cg;
    int   q0;
    q0 = expQ.size();
    sM = 1'b0; dM = 1'b0; cg = 1'b0;
`ifdef OPFETCH_CONST_GEN_EN
    cg = (f == 2'd0) && ((rs == 4'd3) || (rs == 4'd2 && a[1]));
    expCg = cg;
    expCgVal = cg ? cgTable(rs, a) : 16'd0;
`endif
    if (f == 2'd0) begin
      if (!cg && a != 2'd0) begin
        fetchOperand(a, rs, b, 2'd2, sM, dM);
        s = stepBase(sM, dM); s.srcL = 1'b1; expQ.push_back(s);
        sM = 1'b1;
      end
      if (d) begin
        s = stepBase(sM, dM); s.ifetch = 1'b1; expQ.push_back(s);
        s = stepBase(sM, dM); s.addrL = 1'b1; s.idxM = 1'b1; expQ.push_back(s);
        if (!nd) begin
          s = stepBase(sM, dM); s.memRd = 1'b1; expQ.push_back(s);
          s = stepBase(sM, 1'b1); s.dstL = 1'b1; expQ.push_back(s);
          dM = 1'b1;
        end
      end
    end else if (f == 2'd1 && a != 2'd0) begin
      fetchOperand(a, rd, b, 2'd3, sM, dM);
      s = stepBase(sM, 1'b1); s.dstL = 1'b1; expQ.push_back(s);
      dM = 1'b1;
    end
    s = stepBase(sM, dM); s.opValid = 1'b1; expQ.push_back(s);
    n = expQ.size() - q0;
  endtask

  always @(negedge clk) begin
    outT act, e;
    if (!rst) begin
      prevValid = 1'b0;
    end else begin
      act = outVec();
      if (busy) begin
        if (op_valid && prevValid) begin
          check("valid hold", act, heldExp);
        end else if (expQ.size() == 0) begin
          check("unexpected busy cycle", act, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("trace step", act, e);
          if (e.opValid) heldExp = e;
        end
`ifdef OPFETCH_CONST_GEN_EN
        if (op_valid) begin
          check("cg_valid", cg_valid, expCg);
          check("cg_val", cg_val, expCgVal);
        end
`endif
      end
      prevValid = op_valid;
    end
  end

  task automatic runInstr(input logic [1:0] f, input logic [1:0] a, input logic d,
                          input logic b, input logic nd, input logic [3:0] rs,
                          input logic [3:0] rd, input int hold, input logic keepStart,
                          input logic ackNoise);
    int   n, c;
    logic got;
    @(posedge clk); #1;
    fmt = f; As = a; Ad = d; bw = b; no_dst_rd = nd; rs_num = rs; rd_num = rd;
    buildExpected(f, a, d, b, nd, rs, rd, n);
    start = 1'b1;
    @(posedge clk); #1;
    start = keepStart;
    op_ack = ackNoise && (n >= 2);
    got = 1'b0;
    c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 2) op_ack = 1'b0;
      if (op_valid) got = 1'b1;
    end
    op_ack = 1'b0;
    start = 1'b0;
    if (!got) begin
      check("op_valid timeout", 32'd0, 32'd1);
      rst = 1'b0;
      expQ.delete();
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    check("start to op_valid cycles", c, n);
    repeat (hold - 1) @(negedge clk);
    op_ack = 1'b1;
    @(posedge clk); #1;
    op_ack = 1'b0;
    @(negedge clk);
    check("idle after op_ack", {busy, op_valid}, 2'b00);
  endtask

  task automatic resetMidDaddr();
    int n;
    @(posedge clk); #1;
    fmt = 2'd0; As = 2'd0; Ad = 1'b1; bw = 1'b0; no_dst_rd = 1'b1; rs_num = 4'd4; rd_num = 4'd6;
    buildExpected(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd6, n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("D_ADDR AddrL/IdxM", {AddrL, IdxM}, 2'b11);
    rst = 1'b0;
    #1;
    check("outputs in async reset", outVec(), 32'd0);
`ifdef OPFETCH_CONST_GEN_EN
    check("cg outputs in async reset", {cg_valid, cg_val}, 32'd0);
`endif
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle after reset release", {busy, op_valid}, 2'b00);
  endtask

  initial begin
    logic [1:0] rf, ra;
    #1 rst = 1'b0;
    #11;
    check("reset outputs", outVec(), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    runInstr(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd6, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd6, 3, 1'b0, 1'b0);
    runInstr(2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 4'd1, 4'd6, 2, 1'b1, 1'b1);
    runInstr(2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd4, 4'd7, 2, 1'b0, 1'b0);
    runInstr(2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 4'd4, 4'd9, 1, 1'b1, 1'b1);
    runInstr(2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd7, 1, 1'b0, 1'b1);
    runInstr(2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 4'd3, 4'd7, 2, 1'b1, 1'b0);
    runInstr(2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd7, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd6, 1, 1'b0, 1'b0);
    resetMidDaddr();
`ifdef OPFETCH_CONST_GEN_EN
    runInstr(2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd6, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd6, 1, 1'b0, 1'b0);
    runInstr(2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 4'd2, 4'd6, 2, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      rf = 2'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3));
      runInstr(rf, ra, 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom));
    end

    check("scoreboard drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
